// File: rtl/ro_pkg.sv
// Shared types and helpers for the ring-oscillator measurement controller.
package ro_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} ro_state_t;

    localparam int SETTLE_CYCLES_DEF = 16;
    localparam int DIV_LOG2_DEF      = 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ro_meas_ctrl_if.sv
// Request/result bundle between the IO decode (master) and the measurement controller (slave).
interface ro_meas_ctrl_if #(
    parameter int SEL_W  = 2,
    parameter int GATE_W = 8,
    parameter int CNT_W  = 12
);
    logic              start;
    logic              abort;
    logic [SEL_W-1:0]  osc_sel;
    logic [GATE_W-1:0] gate_cycles;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              err;

    modport master (output start, abort, osc_sel, gate_cycles,
                    input  busy, done, count, overflow, err);
    modport slave  (input  start, abort, osc_sel, gate_cycles,
                    output busy, done, count, overflow, err);
endinterface

// File: rtl/ro_prescaler.sv
// Selects one oscillator, divides it in its own domain, and returns a one-cycle
// clk-domain pulse per rising edge of the divided signal.
module ro_prescaler #(
    parameter int NUM_RO   = 4,
    parameter int SEL_W    = 2,
    parameter int DIV_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_RO-1:0] ro_clk,
    input  logic [SEL_W-1:0]  sel,
    output logic              pulse
);
    localparam int DW = DIV_LOG2 + 1;

    logic          ro_mux;
    logic [DW-1:0] div;
    logic [2:0]    sync;

    always_comb begin
        ro_mux = 1'b0;
        for (int i = 0; i < NUM_RO; i++)
            if (sel == SEL_W'(i)) ro_mux = ro_clk[i];
    end

    // Phase of the divider is irrelevant, so it is left without reset.
    always_ff @(posedge ro_mux)
        div <= div + DW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], div[DW-1]};
            pulse <= sync[1] & ~sync[2];
        end
    end
endmodule

// File: rtl/ro_meas_ctrl.sv
// Sequencer for a bank of ring oscillators: one-hot enable, settle window,
// gated edge count with saturation, single-cycle done pulse.
module ro_meas_ctrl
    import ro_pkg::*;
#(
    parameter int NUM_RO        = 4,
    parameter int SEL_W         = 2,
    parameter int GATE_W        = 8,
    parameter int CNT_W         = 12,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int DIV_LOG2      = DIV_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_RO-1:0] ro_clk,
    output logic [NUM_RO-1:0] ro_en,
    ro_meas_ctrl_if.slave     bus
);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    ro_state_t         state;
    logic [SEL_W-1:0]  sel_q;
    logic [GATE_W-1:0] gate_q;
    logic [TMR_W-1:0]  tmr;
    logic [NUM_RO-1:0] ro_en_q;
    logic              busy_q, done_q, ovf_q, err_q;
    logic [CNT_W-1:0]  count_q;
    logic              edge_pulse;

    function automatic logic [NUM_RO-1:0] sel_dec(input logic [SEL_W-1:0] s);
        logic [NUM_RO-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_RO; i++)
            if (s == SEL_W'(i)) d[i] = 1'b1;
        return d;
    endfunction

    ro_prescaler #(.NUM_RO(NUM_RO), .SEL_W(SEL_W), .DIV_LOG2(DIV_LOG2)) u_pre (
        .clk    (clk),
        .rst    (rst),
        .ro_clk (ro_clk),
        .sel    (sel_q),
        .pulse  (edge_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_q   <= '0;
            gate_q  <= '0;
            tmr     <= '0;
            ro_en_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    busy_q  <= 1'b1;
                    count_q <= '0;
                    ovf_q   <= 1'b0;
                    if (32'(bus.osc_sel) >= NUM_RO) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (bus.gate_cycles == '0) begin
                        err_q  <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        err_q   <= 1'b0;
                        sel_q   <= bus.osc_sel;
                        gate_q  <= bus.gate_cycles;
                        ro_en_q <= sel_dec(bus.osc_sel);
                        tmr     <= TMR_W'(SETTLE_CYCLES - 1);
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        ro_en_q <= '0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (tmr == '0) begin
                        tmr   <= TMR_W'(gate_q) - TMR_W'(1);
                        state <= MEASURE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                MEASURE: begin
                    if (bus.abort) begin
                        ro_en_q <= '0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        // Overflow flags an edge that arrived with the counter already pinned.
                        if (edge_pulse) begin
                            count_q <= CNT_W'(sat_inc(32'(count_q), CNT_MAX));
                            if (32'(count_q) == CNT_MAX) ovf_q <= 1'b1;
                        end
                        if (tmr == '0) begin
                            ro_en_q <= '0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ro_en        = ro_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench: dut_a is the nominal 12-bit counter, dut_b a 4-bit counter for saturation.
`timescale 1ns/1ps
module tb_ro_meas_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ro_a = '0;
    logic [3:0] ro_b = '0;
    logic [3:0] en_a, en_b;
    int         tests = 0;
    int         fails = 0;
    int         bad, lat;

    ro_meas_ctrl_if #(.SEL_W(3), .GATE_W(8), .CNT_W(12)) bus_a ();
    ro_meas_ctrl_if #(.SEL_W(3), .GATE_W(8), .CNT_W(4))  bus_b ();

    ro_meas_ctrl #(.NUM_RO(4), .SEL_W(3), .GATE_W(8), .CNT_W(12),
                   .SETTLE_CYCLES(16), .DIV_LOG2(0)) dut_a (
        .clk(clk), .rst(rst), .ro_clk(ro_a), .ro_en(en_a), .bus(bus_a));

    ro_meas_ctrl #(.NUM_RO(4), .SEL_W(3), .GATE_W(8), .CNT_W(4),
                   .SETTLE_CYCLES(16), .DIV_LOG2(0)) dut_b (
        .clk(clk), .rst(rst), .ro_clk(ro_b), .ro_en(en_b), .bus(bus_b));

    always #5 clk = ~clk;

    // ro_a[2]: period 10 clk; ro_b[0]: period 4 clk; both offset from clk edges
    initial begin #2; forever #50 ro_a[2] = ~ro_a[2]; end
    initial begin #3; forever #20 ro_b[0] = ~ro_b[0]; end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_a(input logic [2:0] s, input logic [7:0] g);
        bus_a.osc_sel     = s;
        bus_a.gate_cycles = g;
        bus_a.start       = 1'b1;
        cyc();
        bus_a.start       = 1'b0;
    endtask

    task automatic hold_a(input int n, input logic [3:0] en, output int nbad);
        nbad = 0;
        repeat (n) begin
            cyc();
            if (en_a !== en || bus_a.done !== 1'b0) nbad++;
        end
    endtask

    initial begin
        bus_a.start = 0; bus_a.abort = 0; bus_a.osc_sel = 0; bus_a.gate_cycles = 0;
        bus_b.start = 0; bus_b.abort = 0; bus_b.osc_sel = 0; bus_b.gate_cycles = 0;

        // reset state
        cyc(2);
        chk("rst_busy",  32'(bus_a.busy), 0);
        chk("rst_done",  32'(bus_a.done), 0);
        chk("rst_count", 32'(bus_a.count), 0);
        chk("rst_ovf",   32'(bus_a.overflow), 0);
        chk("rst_err",   32'(bus_a.err), 0);
        chk("rst_en",    32'(en_a), 0);
        chk("rst_en_b",  32'(en_b), 0);
        rst = 1'b0;
        cyc();

        // 1: nominal measurement, 10 prescaled edges expected in 200 cycles
        start_a(3'd2, 8'd200);
        chk("t1_en_c1",   32'(en_a), 32'b0100);
        chk("t1_busy_c1", 32'(bus_a.busy), 1);
        hold_a(215, 4'b0100, bad);
        chk("t1_en_hold", 32'(bad), 0);
        cyc();
        chk("t1_done_c217", 32'(bus_a.done), 1);
        chk("t1_en_off",    32'(en_a), 0);
        chk("t1_count_9_11", 32'(bus_a.count >= 9 && bus_a.count <= 11), 1);
        chk("t1_ovf",       32'(bus_a.overflow), 0);
        chk("t1_err",       32'(bus_a.err), 0);
        cyc();
        chk("t1_done_1cyc", 32'(bus_a.done), 0);
        chk("t1_idle_busy", 32'(bus_a.busy), 0);
        chk("t1_count_held", 32'(bus_a.count >= 9 && bus_a.count <= 11), 1);

        // 2: out-of-range select
        start_a(3'd5, 8'd50);
        chk("t2_done", 32'(bus_a.done), 1);
        chk("t2_err",  32'(bus_a.err), 1);
        chk("t2_count", 32'(bus_a.count), 0);
        chk("t2_en",   32'(en_a), 0);
        cyc();
        chk("t2_busy_off", 32'(bus_a.busy), 0);
        chk("t2_err_held", 32'(bus_a.err), 1);
        chk("t2_en_after", 32'(en_a), 0);

        // 3: zero gate
        start_a(3'd1, 8'd0);
        chk("t3_done",  32'(bus_a.done), 1);
        chk("t3_err",   32'(bus_a.err), 0);
        chk("t3_count", 32'(bus_a.count), 0);
        chk("t3_en",    32'(en_a), 0);
        cyc();
        chk("t3_busy_off", 32'(bus_a.busy), 0);
        chk("t3_en_after", 32'(en_a), 0);

        // 4: saturation on the 4-bit counter, ~31 edges in 255 cycles
        bus_b.osc_sel = 3'd0; bus_b.gate_cycles = 8'd255; bus_b.start = 1'b1;
        cyc();
        bus_b.start = 1'b0;
        chk("t4_en_c1", 32'(en_b), 32'b0001);
        lat = 1;
        while (!bus_b.done && lat < 400) begin cyc(); lat++; end
        chk("t4_latency", 32'(lat), 272);
        chk("t4_count",   32'(bus_b.count), 15);
        chk("t4_ovf",     32'(bus_b.overflow), 1);
        chk("t4_en_off",  32'(en_b), 0);
        cyc();

        // 5a: second start during SETTLE is ignored
        start_a(3'd2, 8'd20);
        cyc(3);
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        lat = 5;
        while (!bus_a.done && lat < 200) begin cyc(); lat++; end
        chk("t5_restart_lat", 32'(lat), 37);
        cyc();

        // 5b: abort in the fifth MEASURE cycle
        start_a(3'd2, 8'd100);
        cyc(19);
        bus_a.abort = 1'b1;
        cyc();
        bus_a.abort = 1'b0;
        chk("t5_abort_busy", 32'(bus_a.busy), 0);
        chk("t5_abort_en",   32'(en_a), 0);
        chk("t5_abort_done", 32'(bus_a.done), 0);
        chk("t5_partial",    32'(bus_a.count <= 1), 1);
        hold_a(120, 4'b0000, bad);
        chk("t5_no_done", 32'(bad), 0);

        // 5c: start and abort together in IDLE, start wins
        bus_a.abort = 1'b1;
        start_a(3'd1, 8'd50);
        chk("t5_sa_busy", 32'(bus_a.busy), 1);
        chk("t5_sa_en",   32'(en_a), 32'b0010);
        cyc();
        chk("t5_sa_abort", 32'(bus_a.busy), 0);
        bus_a.abort = 1'b0;
        cyc();

        // 6: reset during MEASURE, then a fresh measurement
        start_a(3'd5, 8'd10);
        cyc();
        start_a(3'd2, 8'd100);
        cyc(19);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_busy",  32'(bus_a.busy), 0);
        chk("t6_done",  32'(bus_a.done), 0);
        chk("t6_count", 32'(bus_a.count), 0);
        chk("t6_ovf",   32'(bus_a.overflow), 0);
        chk("t6_err",   32'(bus_a.err), 0);
        chk("t6_en",    32'(en_a), 0);
        cyc();
        start_a(3'd2, 8'd200);
        chk("t6_en_c1", 32'(en_a), 32'b0100);
        hold_a(215, 4'b0100, bad);
        chk("t6_en_hold", 32'(bad), 0);
        cyc();
        chk("t6_done_c217", 32'(bus_a.done), 1);
        chk("t6_count_9_11", 32'(bus_a.count >= 9 && bus_a.count <= 11), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ro_meas_ctrl.md
Name: ro_meas_ctrl

Overview:
- Sequencer and arbiter for a bank of NUM_RO on-chip ring oscillators.
- Accepts one measurement request at a time and enables only the selected oscillator, so at most one ring toggles.
- After a settle window, counts prescaled oscillator edges over a programmable gate window in the clk domain, then reports the count.
- Sits between the tt_um_* top-level IO decode and the oscillator instances.

Parameters:
- NUM_RO, 4, number of oscillators under control (2..16).
- SEL_W, 2, width of osc_sel; must satisfy 2^SEL_W >= NUM_RO.
- GATE_W, 8, width of gate_cycles.
- CNT_W, 12, width of count.
- SETTLE_CYCLES, 16, clk cycles the oscillator runs before counting starts (>=1).
- DIV_LOG2, 2, prescaler tap; one count per 2^(DIV_LOG2+1) oscillator periods.

Ports:
- clk  in  1  system clock; the only clock for all control state.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- abort  in  1  cancel the measurement in progress; return to IDLE.
- osc_sel  in  SEL_W  oscillator index, latched on accepted start.
- gate_cycles  in  GATE_W  measurement window in clk cycles, latched on accepted start.
- ro_clk  in  NUM_RO  raw oscillator outputs; asynchronous to clk.
- ro_en  out  NUM_RO  one-hot oscillator enables.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is valid.
- count  out  CNT_W  result; held until the next accepted start.
- overflow  out  1  count saturated during the last measurement.
- err  out  1  last request had osc_sel >= NUM_RO.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, ro_en=0, busy=0, done=0, count=0, overflow=0, err=0, latched registers=0.
  - Reset mid-measurement behaves identically and takes priority over all other inputs.
- FSM states are IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - start=1 with osc_sel<NUM_RO and gate_cycles!=0: latch sel and gate, clear count/overflow/err, go to SETTLE.
  - start=1 with osc_sel>=NUM_RO: err=1, count=0, go to DONE; ro_en stays 0.
  - start=1 with gate_cycles=0: go to DONE with count=0, err=0; no oscillator is enabled.
- SETTLE:
  - ro_en[sel]=1 from the first SETTLE cycle.
  - Stays for exactly SETTLE_CYCLES cycles, then goes to MEASURE.
- MEASURE:
  - Lasts exactly gate cycles.
  - count increments by 1 in each cycle where a synchronized rising edge of the prescaled signal is detected.
  - Saturates at 2^CNT_W-1 and sets overflow=1.
- DONE:
  - Lasts one cycle with done=1, busy=1, ro_en=0.
  - Next state is IDLE.
- Latency from accepted start to done: 1+SETTLE_CYCLES+gate cycles. The error and zero-gate paths take 1 cycle.
- start while busy is ignored; no queueing.
- abort in SETTLE or MEASURE: next cycle is IDLE, ro_en=0, no done pulse, count retains its partial value.
  - abort in IDLE or DONE has no effect.
  - If abort and start arrive together in IDLE, start wins.
- Edge path:
  - ro_clk[sel] is muxed to a single net.
  - A free-running (DIV_LOG2+1)-bit divider clocked by that net feeds a 2-flop synchronizer into clk, then a rising-edge detect.
  - The divider has no reset; its phase is don't-care, giving a ±1 count tolerance.
- Measurable range: the prescaled frequency must stay below clk/4.
- Glitches from mux switching land in the SETTLE window by construction and are never counted.
- ro_en is registered and never has more than one bit set.

Decomposition:
- Shared package ro_pkg holds:
  - FSM state enum (IDLE/SETTLE/MEASURE/DONE);
  - SETTLE_CYCLES and DIV_LOG2 defaults;
  - a saturating-increment function.
- One sub-module, ro_prescaler: mux + divider in the oscillator domain + 2-flop synchronizer + edge detect. Output is a one-cycle clk-domain pulse.
- The FSM, counters and enable decode stay in ro_meas_ctrl.

Test Plan:
1. NUM_RO=4, DIV_LOG2=0, SETTLE_CYCLES=16. ro_clk[2] period=10 clk; start with osc_sel=2, gate=200.
   -> ro_en=4'b0100 for cycles 1..216; done at cycle 217; count=10±1; overflow=0; err=0.
2. osc_sel=5 with NUM_RO=4, start.
   -> done next cycle, err=1, count=0; ro_en stays 0 throughout.
3. gate=0, start.
   -> done after 1 cycle, count=0, ro_en never asserted.
4. CNT_W=4, ro_clk period=4 clk, gate=255.
   -> count=15, overflow=1 at done.
5. abort 5 cycles into MEASURE.
   -> IDLE next cycle, ro_en=0, busy=0, no done pulse.
   - A second start pulse issued during SETTLE is ignored (no restart, latency unchanged).
6. rst=1 for one cycle during MEASURE.
   -> all outputs at reset values on the following cycle.
   - A fresh start afterwards produces a normal measurement.
